// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver (LSB first, idle-high line) with a small
//            valid/ready receive buffer and sticky error flags.
// Revision : 1.0 - initial release
//
// Parameters
//   CLK_FREQ_HZ  system clock frequency in Hz
//   BAUD_RATE    line rate in bit/s (CLK_FREQ_HZ/BAUD_RATE must be >= 4)
//
// Ports
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset
//   i_rx         serial line, asynchronous to clk
//   o_data       byte at the head of the receive buffer
//   o_valid      o_data holds an unread byte
//   i_ready      consumer takes o_data this cycle (when o_valid)
//   o_frame_err  sticky: a stop bit was sampled low
//   o_overrun    sticky: a byte completed while the buffer was full
//   i_clear_err  clears both sticky flags
//
// Configuration
//   UART_RX_FIFO_EN  defined   : 4-entry receive FIFO
//                    undefined : single holding register (depth 1)
// ============================================================================
module uart_rx #(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD_RATE   = 1_000_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  input  logic       i_clear_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  // Pointers keep at least one bit so the depth-1 build still has legal
  // vectors; the spare storage entry in that build is never addressed.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MEM_N = 1 << PTR_W;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(DEPTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  // --------------------------------------------------------------------------
  // Input synchronizer (resets to the idle-high line level)
  // --------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       data_sr;
  logic             cnt_zero;
  logic             push;
  logic             frame_err_set;

  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (!rx_s) next_state = S_START;
      S_START:     if (cnt_zero) next_state = rx_s ? S_IDLE : S_DATA;
      S_DATA:      if (cnt_zero && (bit_idx == 3'd7)) next_state = S_STOP;
      S_STOP:      if (cnt_zero) next_state = rx_s ? S_IDLE : S_WAIT_IDLE;
      S_WAIT_IDLE: if (rx_s) next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  always_comb begin
    push          = 1'b0;
    frame_err_set = 1'b0;
    if ((state == S_STOP) && cnt_zero) begin
      push          = rx_s;
      frame_err_set = !rx_s;
    end
  end

  // Bit timing and data capture. The half-bit preload lands the first sample
  // in the middle of the start bit; every later sample is one bit apart.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      bit_idx <= '0;
      data_sr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rx_s) cnt <= CNT_HALF;
        end
        S_START: begin
          if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else if (!rx_s) begin
            cnt     <= CNT_BIT;
            bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else begin
            data_sr[bit_idx] <= rx_s;
            cnt              <= CNT_BIT;
            bit_idx          <= bit_idx + 1'b1;
          end
        end
        S_STOP: begin
          if (!cnt_zero) cnt <= cnt - 1'b1;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Receive buffer (ring of DEPTH entries, occupancy one bit wider)
  // --------------------------------------------------------------------------
  logic [7:0]       mem [MEM_N];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;
  logic             full;
  logic             pop;
  logic             wr_en;
  logic             overrun_set;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign o_valid = (occ != '0);
  assign o_data  = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a push into a full buffer is
  // still accepted; the head entry is overwritten only after it is read out.
  always_comb begin
    full        = (occ == OCC_FULL);
    pop         = o_valid && i_ready;
    wr_en       = push && (!full || pop);
    overrun_set = push && full && !pop;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MEM_N; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= data_sr;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_en, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky flags: a new event wins over a simultaneous clear
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= frame_err_set || (o_frame_err && !i_clear_err);
      o_overrun   <= overrun_set   || (o_overrun   && !i_clear_err);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx at 10 clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB = 10;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       ovr;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx #(
    .CLK_FREQ_HZ(10_000_000),
    .BAUD_RATE  (1_000_000)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .i_rx       (rx),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_frame_err(ferr),
    .o_overrun  (ovr),
    .i_clear_err(clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n rising edges and land 1 ns after the last one.
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full 8N1 frame; optionally raise i_ready only in the push cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit ready_at_push);
    rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold(CPB);
    end
    rx = stop;
    if (ready_at_push) begin
      hold(7);
      ready = 1'b1;
      hold(1);
      ready = 1'b0;
      hold(2);
    end else begin
      hold(CPB);
    end
    rx = 1'b1;
  endtask

  task automatic pop_one();
    ready = 1'b1;
    hold(1);
    ready = 1'b0;
  endtask

  task automatic clear_flags();
    clear = 1'b1;
    hold(1);
    clear = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0};
    vecs[1] = '{8'hA3, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0};
    vecs[5] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};

    // Reset state
    hold(3);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_ferr", ferr, 0);
    check("rst_ovr", ovr, 0);
    resetn = 1'b1;
    hold(5);

    // Latency from start edge to o_valid
    fork
      send_frame(8'h55, 1'b1, 1'b0);
      begin
        int cyc = 0;
        while (!valid && cyc < 200) begin
          @(posedge clk);
          #1;
          cyc++;
        end
        n_cmp++;
        if (cyc < 96 || cyc > 98) begin
          n_bad++;
          $display("FAIL latency: got %0d cycles expected 96..98", cyc);
        end
      end
    join
    check("lat_data", data, 8'h55);
    check("lat_ferr", ferr, 0);
    pop_one();
    check("lat_empty", valid, 0);

    // Table-driven frames
    foreach (vecs[k]) begin
      send_frame(vecs[k].data, vecs[k].stop, 1'b0);
      hold(4);
      check($sformatf("vec%0d_valid", k), valid, vecs[k].exp_valid);
      if (vecs[k].exp_valid) check($sformatf("vec%0d_data", k), data, vecs[k].exp_data);
      check($sformatf("vec%0d_ferr", k), ferr, vecs[k].exp_ferr);
      check($sformatf("vec%0d_ovr", k), ovr, 0);
      if (vecs[k].exp_valid) pop_one();
      check($sformatf("vec%0d_drained", k), valid, 0);
      clear_flags();
      check($sformatf("vec%0d_cleared", k), ferr, 0);
    end

    // Short glitch is rejected, receiver still works afterwards
    rx = 1'b0;
    hold(3);
    rx = 1'b1;
    hold(30);
    check("glitch_valid", valid, 0);
    check("glitch_ferr", ferr, 0);
    check("glitch_ovr", ovr, 0);
    send_frame(8'hC3, 1'b1, 1'b0);
    hold(2);
    check("post_glitch_valid", valid, 1);
    check("post_glitch_data", data, 8'hC3);
    pop_one();

    // i_ready with an empty buffer does nothing
    ready = 1'b1;
    hold(5);
    ready = 1'b0;
    check("ready_empty", valid, 0);
    send_frame(8'h5A, 1'b1, 1'b0);
    hold(2);
    check("after_ready_valid", valid, 1);
    check("after_ready_data", data, 8'h5A);
    pop_one();
    check("after_ready_empty", valid, 0);

    // Overrun: five back-to-back bytes, nobody reading
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b1, 1'b0);
      check($sformatf("ovr_after_%0d", k), ovr, (k > DEPTH) ? 1 : 0);
    end
    hold(2);
    for (int j = 1; j <= DEPTH; j++) begin
      check($sformatf("ovr_valid_%0d", j), valid, 1);
      check($sformatf("ovr_data_%0d", j), data, j);
      pop_one();
    end
    check("ovr_drained", valid, 0);
    clear_flags();
    check("ovr_cleared", ovr, 0);

    // Full buffer, pop in the same cycle as the next push
    for (int j = 0; j < DEPTH; j++) send_frame(8'h10 + 8'(j), 1'b1, 1'b0);
    check("full_no_ovr", ovr, 0);
    send_frame(8'hEE, 1'b1, 1'b1);
    hold(2);
    check("pushpop_ovr", ovr, 0);
    for (int j = 1; j < DEPTH; j++) begin
      check($sformatf("pushpop_data_%0d", j), data, 8'h10 + 8'(j));
      pop_one();
    end
    check("pushpop_last_valid", valid, 1);
    check("pushpop_last_data", data, 8'hEE);
    pop_one();
    check("pushpop_drained", valid, 0);

    // Reset in the middle of a frame (bit 4 of 0xFF) with a byte pending
    send_frame(8'h77, 1'b1, 1'b0);
    hold(2);
    check("pre_rst_valid", valid, 1);
    rx = 1'b0;
    hold(CPB);
    rx = 1'b1;
    hold(4 * CPB + 5);
    resetn = 1'b0;
    hold(2);
    check("midrst_valid", valid, 0);
    check("midrst_data", data, 0);
    resetn = 1'b1;
    hold(45);
    check("midrst_no_byte", valid, 0);
    send_frame(8'h3C, 1'b1, 1'b0);
    hold(2);
    check("midrst_valid_3c", valid, 1);
    check("midrst_data_3c", data, 8'h3C);
    check("midrst_ferr", ferr, 0);
    check("midrst_ovr", ovr, 0);
    pop_one();
    hold(20);
    check("midrst_only_one", valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
